// File: rtl/program_loader_if.sv
// Instruction handshake and program-RAM write bus between an instruction source and the loader.
interface program_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [2:0]        in_rx;
    logic [2:0]        in_ry;
    logic [DATA_W-1:0] in_imm;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output in_valid, in_op, in_rx, in_ry, in_imm,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_op, in_rx, in_ry, in_imm,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/program_loader.sv
// Encodes symbolic instructions into IIXXXYYY words and writes them sequentially into program RAM;
// mvi emits the instruction word followed by its immediate.
module program_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2 ** ADDR_W,
    parameter int DATA_W = 8
) (
    input  logic              M_clock,
    input  logic              resetn,
    input  logic              clear,
    program_loader_if.slave   bus,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              overflow
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WR_INSTR = 2'd1;
    localparam logic [1:0] WR_IMM   = 2'd2;

    localparam logic [1:0]      OP_MVI  = 2'b01;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state;
    logic              mvi_q;
    logic [DATA_W-1:0] imm_q;

    logic              accept;
    logic              is_mvi;
    logic              room_ok;
    logic [DATA_W-1:0] enc_word;
    logic [ADDR_W:0]   count_inc;

    assign bus.in_ready = (state == IDLE) && !full && !clear;
    assign full         = (word_count == DEPTH_C);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_mvi       = (bus.in_op == OP_MVI);

    // mvi needs two free slots so it is never split across the end of RAM
    assign room_ok  = is_mvi ? (word_count <= DEPTH_C - (ADDR_W + 1)'(2))
                             : (word_count <  DEPTH_C);
    assign enc_word = DATA_W'({bus.in_op, bus.in_rx, (is_mvi ? 3'b000 : bus.in_ry)});

    // saturating increment: the address never wraps past the last slot
    assign count_inc = (word_count == DEPTH_C) ? word_count : word_count + 1'b1;

    always_ff @(posedge M_clock) begin
        if (resetn || clear) begin
            state      <= IDLE;
            bus.wr_en  <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            mvi_q      <= 1'b0;
            if (resetn) imm_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.wr_en <= 1'b0;
                    if (accept) begin
                        if (room_ok) begin
                            bus.wr_en   <= 1'b1;
                            bus.wr_addr <= word_count[ADDR_W-1:0];
                            bus.wr_data <= enc_word;
                            word_count  <= count_inc;
                            imm_q       <= bus.in_imm;
                            mvi_q       <= is_mvi;
                            state       <= WR_INSTR;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                WR_INSTR: begin
                    if (mvi_q) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= word_count[ADDR_W-1:0];
                        bus.wr_data <= imm_q;
                        word_count  <= count_inc;
                        state       <= WR_IMM;
                    end else begin
                        bus.wr_en <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WR_IMM: begin
                    bus.wr_en <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    bus.wr_en <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed plus randomized checks of program_loader against a queue-based model of the RAM write stream.
module tb_program_loader;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic resetn;
    logic clear;
    logic [ADDR_W:0] word_count;
    logic full;
    logic overflow;

    int checks   = 0;
    int failures = 0;

    // model: expected write stream plus word count and sticky overflow
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int   m_count;
    logic m_ovf;

    program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .M_clock   (clk),
        .resetn    (resetn),
        .clear     (clear),
        .bus       (bus.slave),
        .word_count(word_count),
        .full      (full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.wr_en === 1'b1) got_q.push_back({8'(bus.wr_addr), bus.wr_data});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_accept(input logic [1:0] op, input logic [2:0] rx, input logic [2:0] ry,
                                input logic [7:0] imm);
        logic [7:0] w;
        w = {op, rx, (op == 2'b01) ? 3'b000 : ry};
        if (op == 2'b01) begin
            if (m_count + 2 <= DEPTH) begin
                exp_q.push_back({8'(m_count), w});
                exp_q.push_back({8'(m_count + 1), imm});
                m_count += 2;
            end else m_ovf = 1'b1;
        end else if (m_count < DEPTH) begin
            exp_q.push_back({8'(m_count), w});
            m_count += 1;
        end
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_word"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_count"}, word_count, m_count);
        chk({tag, "_ovf"}, overflow, m_ovf);
        chk({tag, "_full"}, full, (m_count == DEPTH));
    endtask

    task automatic do_reset();
        resetn = 1'b1; clear = 1'b0; bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
        m_count = 0; m_ovf = 1'b0;
        got_q.delete(); exp_q.delete();
    endtask

    // called and returns at 1 time unit after a rising edge
    task automatic send(input logic [1:0] op, input logic [2:0] rx, input logic [2:0] ry,
                        input logic [7:0] imm);
        int n;
        logic rdy;
        bus.in_op = op; bus.in_rx = rx; bus.in_ry = ry; bus.in_imm = imm;
        bus.in_valid = 1'b1;
        if (m_count == DEPTH) begin
            repeat (3) begin
                @(negedge clk);
                chk("full_blocks", bus.in_ready, 1'b0);
            end
            @(posedge clk); #1 bus.in_valid = 1'b0;
        end else begin
            n = 0;
            @(negedge clk);
            while (bus.in_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
            rdy = bus.in_ready;
            chk("ready_seen", rdy, 1'b1);
            @(posedge clk); #1 bus.in_valid = 1'b0;
            if (rdy === 1'b1) model_accept(op, rx, ry, imm);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic fill_to(input int target);
        logic [1:0] op;
        while (m_count < target) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'b01 && m_count + 2 > target) op = 2'b00;
            send(op, 3'($urandom), 3'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        bus.in_op = '0; bus.in_rx = '0; bus.in_ry = '0; bus.in_imm = '0;
        bus.in_valid = 1'b0; clear = 1'b0; resetn = 1'b1;

        // 1: reset state, then mv R1,R0
        do_reset();
        @(negedge clk);
        chk("rst_wr_en", bus.wr_en, 1'b0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_ready", bus.in_ready, 1'b1);
        check_status("rst");
        @(posedge clk); #1;
        send(2'b00, 3'd1, 3'd0, 8'h00);
        chk("mv_data", exp_q[0], {8'd0, 8'h08});
        check_writes("t1");
        check_status("t1");

        // 2: mvi R0,#5A at count 1 -- instr then imm on consecutive cycles
        bus.in_op = 2'b01; bus.in_rx = 3'd0; bus.in_ry = 3'd7; bus.in_imm = 8'h5A;
        bus.in_valid = 1'b1;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        model_accept(2'b01, 3'd0, 3'd7, 8'h5A);
        @(negedge clk);
        chk("mvi_instr", {bus.wr_en, 3'b0, bus.wr_addr, bus.wr_data}, {1'b1, 3'b0, 5'd1, 8'h40});
        chk("mvi_rdy1", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("mvi_imm", {bus.wr_en, 3'b0, bus.wr_addr, bus.wr_data}, {1'b1, 3'b0, 5'd2, 8'h5A});
        chk("mvi_rdy2", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("mvi_idle", bus.wr_en, 1'b0);
        chk("mvi_rdy3", bus.in_ready, 1'b1);
        check_writes("t2");
        check_status("t2");
        @(posedge clk); #1;

        // 3: add R0,R1 then sub R1,R0 with in_valid held throughout
        do_reset();
        bus.in_op = 2'b10; bus.in_rx = 3'd0; bus.in_ry = 3'd1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        model_accept(2'b10, 3'd0, 3'd1, 8'h00);
        bus.in_op = 2'b11; bus.in_rx = 3'd1; bus.in_ry = 3'd0;
        @(negedge clk);
        chk("b2b_gap", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("b2b_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        model_accept(2'b11, 3'd1, 3'd0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_words", {exp_q[0], exp_q[1]}, {8'd0, 8'h81, 8'd1, 8'hC8});
        check_writes("t3");

        // 4: 31 words, mvi dropped whole, then mv fills the last slot
        do_reset();
        fill_to(31);
        send(2'b01, 3'd3, 3'd0, 8'hEE);
        chk("drop_ovf", overflow, 1'b1);
        chk("drop_count", word_count, 31);
        check_writes("t4a");
        send(2'b00, 3'd2, 3'd5, 8'h00);
        chk("last_addr", exp_q[0][15:8], 31);
        check_writes("t4b");
        check_status("t4");
        chk("full_ready", bus.in_ready, 1'b0);
        send(2'b10, 3'd1, 3'd1, 8'h00);
        check_writes("t4c");

        // 5: reset lands on the edge that would launch the immediate
        do_reset();
        send(2'b00, 3'd4, 3'd4, 8'h00);
        bus.in_op = 2'b01; bus.in_rx = 3'd2; bus.in_ry = 3'd3; bus.in_imm = 8'hA5;
        bus.in_valid = 1'b1;
        @(posedge clk); #1 bus.in_valid = 1'b0; resetn = 1'b1;
        exp_q.push_back({8'd1, 8'h50});
        @(negedge clk);
        chk("abort_instr", {bus.wr_en, bus.wr_data}, {1'b1, 8'h50});
        @(posedge clk); #1 resetn = 1'b0;
        m_count = 0; m_ovf = 1'b0;
        @(negedge clk);
        chk("abort_wr_en", bus.wr_en, 1'b0);
        chk("abort_count", word_count, 0);
        chk("abort_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("abort_no_imm", bus.wr_en, 1'b0);
        check_writes("t5");
        @(posedge clk); #1;

        // 6: clear with in_valid high and overflow set
        do_reset();
        fill_to(31);
        send(2'b01, 3'd0, 3'd0, 8'h11);
        chk("pre_clear_ovf", overflow, 1'b1);
        bus.in_op = 2'b00; bus.in_rx = 3'd1; bus.in_ry = 3'd0; bus.in_valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        chk("clear_ready", bus.in_ready, 1'b0);
        @(posedge clk); #1 clear = 1'b0; bus.in_valid = 1'b0;
        m_count = 0; m_ovf = 1'b0;
        @(negedge clk);
        chk("clear_wr_en", bus.wr_en, 1'b0);
        check_status("clear");
        check_writes("t6a");
        @(posedge clk); #1;
        send(2'b00, 3'd1, 3'd0, 8'h00);
        chk("post_clear_mv", exp_q[0], {8'd0, 8'h08});
        check_writes("t6b");

        // randomized traffic with periodic clears, run past full
        do_reset();
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            send(2'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
            if (i % 10 == 9) check_status("rnd");
            if (i % 40 == 39) begin
                clear = 1'b1;
                @(posedge clk); #1 clear = 1'b0;
                m_count = 0; m_ovf = 1'b0;
                check_writes("rnd");
            end
        end
        check_status("rnd_end");
        check_writes("rnd_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
